// File: rtl/inverter_bist_pkg.sv
// Shared types and sizing helpers for the inverter bank self-test.
package inverter_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_CHECK  = 2'd2,
        ST_FINISH = 2'd3
    } bist_state_e;

    // Four fixed patterns (zeros, ones, 0x55.., 0xAA..) plus one walking-one per cell.
    function automatic int npat(input int width);
        return width + 4;
    endfunction

    // Width of an index that can address n patterns.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/inverter_pattern_gen.sv
// Combinational map from pattern index to the word driven onto the bank inputs.
module inverter_pattern_gen
    import inverter_bist_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [idx_width(npat(WIDTH))-1:0] idx_i,
    output logic [WIDTH-1:0]                  pat_o
);

    localparam int IW = idx_width(npat(WIDTH));
    localparam logic [IW-1:0]    IDX_WALK = IW'(4);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    // 0x55.. pattern: bit 0 set, alternating upwards.
    logic [WIDTH-1:0] alt_even;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_alt
        assign alt_even[gi] = ((gi % 2) == 0);
    end

    // Indices 0..3 are the fixed patterns, everything above walks a single one.
    always_comb begin
        pat_o = '0;
        if (idx_i == IW'(0)) begin
            pat_o = '0;
        end else if (idx_i == IW'(1)) begin
            pat_o = '1;
        end else if (idx_i == IW'(2)) begin
            pat_o = alt_even;
        end else if (idx_i == IW'(3)) begin
            pat_o = ~alt_even;
        end else begin
            pat_o = ONE << (idx_i - IDX_WALK);
        end
    end

endmodule

// File: rtl/inverter_bank_bist.sv
// Self-test sequencer: walks the pattern set over the inverter bank, holds each
// pattern for SETTLE cycles, then compares the bank outputs against the
// complement of the driven word and accumulates the results.
module inverter_bank_bist
    import inverter_bist_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int SETTLE = 2,
    localparam int NPAT   = npat(WIDTH),
    localparam int IW     = idx_width(NPAT),
    localparam int CW     = $clog2(NPAT + 1),
    localparam int SW     = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1)
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             start_i,
    input  logic             abort_i,
    output logic [WIDTH-1:0] inv_in_o,
    input  logic [WIDTH-1:0] inv_out_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [CW-1:0]    fail_count_o,
    output logic [IW-1:0]    first_fail_idx_o,
    output logic [WIDTH-1:0] err_mask_o
);

    bist_state_e      state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [SW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    fail_count_q, fail_count_d;
    logic [IW-1:0]    first_fail_q, first_fail_d;
    logic [WIDTH-1:0] err_mask_q, err_mask_d;
    logic             pass_q, pass_d;

    logic [WIDTH-1:0] pattern;
    logic [WIDTH-1:0] mism;

    inverter_pattern_gen #(
        .WIDTH(WIDTH)
    ) u_pattern_gen (
        .idx_i (idx_q),
        .pat_o (pattern)
    );

    // A healthy cell drives the complement of its input; any other bit is a fault.
    assign mism = inv_out_i ^ ~pattern;

    // Next-state, result update and state-decoded outputs.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        fail_count_d = fail_count_q;
        first_fail_d = first_fail_q;
        err_mask_d   = err_mask_q;
        pass_d       = pass_q;
        inv_in_o     = '0;
        busy_o       = 1'b0;
        done_o       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i && !abort_i) begin
                    fail_count_d = '0;
                    first_fail_d = '0;
                    err_mask_d   = '0;
                    pass_d       = 1'b0;
                    idx_d        = '0;
                    cnt_d        = '0;
                    state_d      = ST_APPLY;
                end
            end
            ST_APPLY: begin
                inv_in_o = pattern;
                busy_o   = 1'b1;
                if (cnt_q == SW'(SETTLE - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_CHECK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_CHECK: begin
                inv_in_o = pattern;
                busy_o   = 1'b1;
                if (mism != '0) begin
                    if (fail_count_q == '0) begin
                        first_fail_d = idx_q;
                    end
                    if (fail_count_q != CW'(NPAT)) begin
                        fail_count_d = fail_count_q + 1'b1;
                    end
                end
                err_mask_d = err_mask_q | mism;
                if (idx_q == IW'(NPAT - 1)) begin
                    state_d = ST_FINISH;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_APPLY;
                end
            end
            ST_FINISH: begin
                busy_o  = 1'b1;
                done_o  = 1'b1;
                pass_d  = (fail_count_q == '0);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort beats everything, including a pending CHECK update: partial
        // counts stay as they were before this cycle and the run reads as failed.
        if (abort_i && (state_q != ST_IDLE)) begin
            state_d      = ST_IDLE;
            idx_d        = '0;
            cnt_d        = '0;
            fail_count_d = fail_count_q;
            first_fail_d = first_fail_q;
            err_mask_d   = err_mask_q;
            pass_d       = 1'b0;
        end
    end

    // State, counters and result registers; reset clears everything at once.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            fail_count_q <= '0;
            first_fail_q <= '0;
            err_mask_q   <= '0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            fail_count_q <= fail_count_d;
            first_fail_q <= first_fail_d;
            err_mask_q   <= err_mask_d;
            pass_q       <= pass_d;
        end
    end

    assign pass_o           = pass_q;
    assign fail_count_o     = fail_count_q;
    assign first_fail_idx_o = first_fail_q;
    assign err_mask_o       = err_mask_q;

endmodule

// File: tb/tb_inverter_bank_bist.sv
// Bench for inverter_bank_bist: two instances (SETTLE=2 and SETTLE=3) each
// beside a configurable inverter bank model (delay 1..3, stuck-at masks).
module tb_inverter_bank_bist;

    localparam int NPAT = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    logic start_r, abort_r;
    int   sel;
    int   delay;
    logic [7:0] s0, s1;

    int tests = 0;
    int fails = 0;

    logic       start_a, abort_a, start_b, abort_b;
    logic [7:0] inv_in_a, inv_out_a, em_a, inv_in_b, inv_out_b, em_b;
    logic       busy_a, done_a, pass_a, busy_b, done_b, pass_b;
    logic [3:0] fc_a, ff_a, fc_b, ff_b;

    assign start_a = (sel == 0) ? start_r : 1'b0;
    assign abort_a = (sel == 0) ? abort_r : 1'b0;
    assign start_b = (sel == 1) ? start_r : 1'b0;
    assign abort_b = (sel == 1) ? abort_r : 1'b0;

    logic       busy_m, done_m, pass_m;
    logic [7:0] inv_in_m, em_m;
    logic [3:0] fc_m, ff_m;
    assign busy_m   = (sel == 0) ? busy_a   : busy_b;
    assign done_m   = (sel == 0) ? done_a   : done_b;
    assign pass_m   = (sel == 0) ? pass_a   : pass_b;
    assign inv_in_m = (sel == 0) ? inv_in_a : inv_in_b;
    assign em_m     = (sel == 0) ? em_a     : em_b;
    assign fc_m     = (sel == 0) ? fc_a     : fc_b;
    assign ff_m     = (sel == 0) ? ff_a     : ff_b;

    inverter_bank_bist #(.WIDTH(8), .SETTLE(2)) dut_a (
        .clk_i(clk), .reset_n_i(reset_n), .start_i(start_a), .abort_i(abort_a),
        .inv_in_o(inv_in_a), .inv_out_i(inv_out_a), .busy_o(busy_a), .done_o(done_a),
        .pass_o(pass_a), .fail_count_o(fc_a), .first_fail_idx_o(ff_a), .err_mask_o(em_a)
    );

    inverter_bank_bist #(.WIDTH(8), .SETTLE(3)) dut_b (
        .clk_i(clk), .reset_n_i(reset_n), .start_i(start_b), .abort_i(abort_b),
        .inv_in_o(inv_in_b), .inv_out_i(inv_out_b), .busy_o(busy_b), .done_o(done_b),
        .pass_o(pass_b), .fail_count_o(fc_b), .first_fail_idx_o(ff_b), .err_mask_o(em_b)
    );

    // Bank model: output is the complement of the input 'delay' cycles ago,
    // then forced by the stuck-at-1 and stuck-at-0 masks.
    logic [7:0] pa1 = '0, pa2 = '0, pa3 = '0, pb1 = '0, pb2 = '0, pb3 = '0;
    always @(posedge clk) begin
        pa1 <= inv_in_a; pa2 <= pa1; pa3 <= pa2;
        pb1 <= inv_in_b; pb2 <= pb1; pb3 <= pb2;
    end

    function automatic logic [7:0] bank(input logic [7:0] d1, input logic [7:0] d2,
                                        input logic [7:0] d3, input int dl,
                                        input logic [7:0] m0, input logic [7:0] m1);
        logic [7:0] x;
        x = (dl == 1) ? d1 : ((dl == 2) ? d2 : d3);
        return (~x | m1) & ~m0;
    endfunction

    assign inv_out_a = bank(pa1, pa2, pa3, delay, s0, s1);
    assign inv_out_b = bank(pb1, pb2, pb3, delay, s0, s1);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: the pattern table as listed for the bank test.
    function automatic logic [7:0] pat(input int k);
        logic [7:0] one;
        one = 8'h01;
        case (k)
            0: return 8'h00;
            1: return 8'hFF;
            2: return 8'h55;
            3: return 8'hAA;
            default: return one << (k - 4);
        endcase
    endfunction

    // Word on the bank inputs during cycle c of a run (cycle 0 = start-accept cycle).
    function automatic logic [7:0] drv(input int c, input int s);
        if (c < 1 || c > NPAT * (s + 1)) return 8'h00;
        return pat((c - 1) / (s + 1));
    endfunction

    // Results from all checks that complete before cycle lim of a run.
    task automatic model(input int s, input int lim, output int fc, output int ff,
                         output logic [7:0] em);
        logic [7:0] obs, m;
        fc = 0; ff = 0; em = 8'h00;
        for (int k = 0; k < NPAT; k++) begin
            int c;
            c = (k + 1) * (s + 1);
            if (c >= lim) break;
            obs = (~drv(c - delay, s) | s1) & ~s0;
            m   = obs ^ ~pat(k);
            if (m != 8'h00) begin
                if (fc == 0) ff = k;
                fc++;
            end
            em |= m;
        end
    endtask

    // One run on the selected instance; abort_at/start_at < 0 means never.
    task automatic run(input int which, input int abort_at, input int start_at);
        int s, len, fc, ff;
        logic [7:0] em;
        bit aborted;
        sel = which;
        s = (which == 0) ? 2 : 3;
        len = NPAT * (s + 1) + 1;
        aborted = 0;
        repeat (4) tick;
        check_eq("idle_busy", busy_m, 0);
        start_r = 1'b1;
        tick;
        start_r = 1'b0;
        for (int n = 1; n <= len; n++) begin
            check_eq("busy", busy_m, 1);
            check_eq("inv_in", inv_in_m, (n < len) ? drv(n, s) : 8'h00);
            check_eq("done", done_m, (n == len) ? 1 : 0);
            start_r = (n == start_at);
            abort_r = (n == abort_at);
            tick;
            start_r = 1'b0;
            abort_r = 1'b0;
            if (n == abort_at) begin
                aborted = 1;
                break;
            end
        end
        check_eq("end_busy", busy_m, 0);
        check_eq("end_done", done_m, 0);
        check_eq("end_inv_in", inv_in_m, 0);
        if (aborted) begin
            check_eq("abort_pass", pass_m, 0);
            if ((abort_at % (s + 1)) != 0) begin
                model(s, abort_at, fc, ff, em);
                check_eq("abort_fail_count", fc_m, fc);
                check_eq("abort_first_fail", ff_m, ff);
                check_eq("abort_err_mask", em_m, em);
            end
        end else begin
            model(s, 1 << 30, fc, ff, em);
            check_eq("pass", pass_m, (fc == 0) ? 1 : 0);
            check_eq("fail_count", fc_m, fc);
            check_eq("first_fail", ff_m, ff);
            check_eq("err_mask", em_m, em);
        end
    endtask

    initial begin
        reset_n = 1'b1;
        start_r = 1'b0;
        abort_r = 1'b0;
        sel = 0;
        delay = 1;
        s0 = 8'h00;
        s1 = 8'h00;
        #1 reset_n = 1'b0;
        #1;
        check_eq("rst_busy", busy_m, 0);
        check_eq("rst_done", done_m, 0);
        check_eq("rst_pass", pass_m, 0);
        check_eq("rst_inv_in", inv_in_m, 0);
        check_eq("rst_fail_count", fc_m, 0);
        check_eq("rst_first_fail", ff_m, 0);
        check_eq("rst_err_mask", em_m, 0);
        repeat (3) tick;
        reset_n = 1'b1;

        // Healthy bank, defaults.
        run(0, -1, -1);
        check_eq("healthy_pass", pass_m, 1);

        // Bit 3 stuck at 0, with a stray start on cycle 5 of the run.
        s0 = 8'h08;
        run(0, -1, 5);
        check_eq("stuck_fail_count", fc_m, 9);
        check_eq("stuck_err_mask", em_m, 8'h08);
        check_eq("stuck_first_fail", ff_m, 0);
        s0 = 8'h00;

        // Slow bank: too short a settle time fails, a longer one passes.
        delay = 3;
        run(0, -1, -1);
        check_eq("slow_s2_pass", pass_m, 0);
        run(1, -1, -1);
        check_eq("slow_s3_pass", pass_m, 1);
        delay = 1;

        // Abort on cycle 10, then a normal run.
        run(0, 10, -1);
        run(0, -1, -1);

        // start and abort together in IDLE.
        sel = 0;
        start_r = 1'b1;
        abort_r = 1'b1;
        tick;
        start_r = 1'b0;
        abort_r = 1'b0;
        check_eq("start_abort_busy", busy_m, 0);
        tick;
        check_eq("start_abort_busy2", busy_m, 0);

        // Asynchronous reset during CHECK of pattern 1.
        s0 = 8'h08;
        repeat (4) tick;
        start_r = 1'b1;
        tick;
        start_r = 1'b0;
        repeat (5) tick;
        check_eq("pre_rst_inv_in", inv_in_m, 8'hFF);
        check_eq("pre_rst_fail_count", fc_m, 1);
        reset_n = 1'b0;
        #1;
        check_eq("arst_busy", busy_m, 0);
        check_eq("arst_inv_in", inv_in_m, 0);
        check_eq("arst_fail_count", fc_m, 0);
        check_eq("arst_err_mask", em_m, 0);
        check_eq("arst_pass", pass_m, 0);
        tick;
        tick;
        reset_n = 1'b1;
        s0 = 8'h00;
        for (int i = 0; i < 3; i++) begin
            tick;
            check_eq("post_rst_busy", busy_m, 0);
            check_eq("post_rst_inv_in", inv_in_m, 0);
        end

        // Randomized faults, delays, aborts and stray starts.
        for (int r = 0; r < 12; r++) begin
            int which, len, ab, st;
            which = $urandom_range(0, 1);
            len = NPAT * ((which == 0) ? 3 : 4) + 1;
            delay = $urandom_range(1, 3);
            s0 = ($urandom_range(0, 1) == 1) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
            s1 = ($urandom_range(0, 2) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
            ab = ($urandom_range(0, 2) == 0) ? $urandom_range(2, len - 1) : -1;
            st = $urandom_range(1, len);
            run(which, ab, st);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/inverter_bank_bist.md
Name: inverter_bank_bist

Overview:
- Built-in self-test sequencer for a bank of WIDTH inverter cells, instantiated as WIDTH parallel inverters.
- Drives a fixed pattern sequence onto the bank inputs, waits a programmable settle time, then samples the bank outputs against the bitwise complement of the driven pattern.
- Reports pass/fail, mismatch count, first failing pattern index and a sticky per-bit error mask through a start/done handshake.
- Sits beside the inverter bank in the test harness; a host or the harness controller starts it.

Parameters:
- WIDTH, 8, number of inverter cells in the bank (>=2).
- SETTLE, 2, cycles a pattern is held before sampling (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a run; honoured only in IDLE.
- abort  input  1  synchronous abort; returns to IDLE from any state.
- inv_in  output  WIDTH  pattern driven to the bank inputs.
- inv_out  input  WIDTH  bank outputs.
- busy  output  1  high while a run is in progress.
- done  output  1  one-cycle pulse when a run completes.
- pass  output  1  1 when the last completed run had zero mismatches.
- fail_count  output  clog2(NPAT+1)  number of patterns that mismatched.
- first_fail_idx  output  clog2(NPAT)  index of the first mismatching pattern; 0 if pass.
- err_mask  output  WIDTH  OR of (inv_out XOR ~inv_in) over all checks in the run.

Behaviour:
- Number of patterns: NPAT = WIDTH+4.
- Pattern index order:
  - 0: all zeros.
  - 1: all ones.
  - 2: 0x55..
  - 3: 0xAA..
  - 4..WIDTH+3: walking one, with index k = 1<<(k-4).
- Reset values: inv_in=0, busy=0, done=0, pass=0, fail_count=0, first_fail_idx=0, err_mask=0. State is IDLE, pattern index 0, settle counter 0.
- States: IDLE, APPLY, CHECK, FINISH.
- IDLE:
  - inv_in=0.
  - start=1 and abort=0: clear fail_count, first_fail_idx, err_mask and pass; set index=0; go to APPLY.
  - Results from the previous run hold until the next accepted start.
- APPLY:
  - inv_in = pattern(index) from the first APPLY cycle.
  - Stay SETTLE cycles, then go to CHECK.
- CHECK (1 cycle):
  - Compute mism = inv_out XOR ~inv_in.
  - If mism != 0: fail_count++. If this is the first failure of the run, first_fail_idx = index.
  - err_mask |= mism. inv_in is held.
  - If index = NPAT-1, go to FINISH; otherwise index++ and go to APPLY.
- FINISH (1 cycle):
  - done=1; pass=(fail_count==0) is registered on exit. inv_in=0.
  - Return to IDLE.
- busy=1 in APPLY, CHECK and FINISH.
- Run length: NPAT*(SETTLE+1) cycles of APPLY/CHECK, plus 1 FINISH cycle. With defaults: 36+1. done is asserted in the 37th cycle after the start-accept edge.
- Arithmetic:
  - fail_count saturates at NPAT and cannot overflow by construction.
  - The settle counter is clog2(SETTLE+1) wide and wraps to 0 on leaving APPLY.
- Boundary conditions:
  - start while busy: ignored, with no effect on the run.
  - abort and start in the same IDLE cycle: abort wins; the block stays in IDLE.
  - abort in APPLY/CHECK/FINISH: next state is IDLE, inv_in=0, busy=0, no done pulse, pass=0. fail_count and err_mask keep their partial values.
  - reset_n low mid-run: all outputs go to their reset values immediately (asynchronous).
  - inv_out is treated as synchronous to clk; the harness guarantees settling within SETTLE cycles.

Decomposition:
- Package inverter_bist_pkg holds:
  - the state enum (IDLE, APPLY, CHECK, FINISH);
  - the NPAT derivation function;
  - the index-width function.
- Sub-module inverter_pattern_gen: purely combinational; maps index to pattern; parameter WIDTH.
- The FSM, counters and result registers live in inverter_bank_bist.

Test Plan:
- Healthy bank model (inv_out = ~inv_in registered 1 cycle), defaults; pulse start:
  - busy rises the next cycle;
  - done pulses 37 cycles after the start-accept edge;
  - pass=1, fail_count=0, err_mask=0x00, first_fail_idx=0.
- Bit 3 stuck at 0 on inv_out, WIDTH=8:
  - fail_count=9 (indices 0, 2 and the 7 walking-one patterns other than 0x08);
  - first_fail_idx=0, err_mask=0x08, pass=0.
- Slow bank (3-cycle output delay) with SETTLE=2:
  - mismatches are detected and pass=0;
  - rerun with SETTLE=3 gives pass=1.
- Abort on cycle 10 of a run:
  - IDLE on the next cycle; busy=0, inv_in=0;
  - no done pulse, pass=0;
  - a fresh start afterwards completes a normal 37-cycle run.
- start pulsed on cycle 5 of a run:
  - ignored; done still arrives at cycle 37 with the original results.
  - start and abort together in IDLE: busy stays 0.
- reset_n asserted during CHECK:
  - all outputs are 0 asynchronously, before the next clk edge;
  - after release, the block stays IDLE until start.
